// File: rtl/mnist_batch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mnist_batch_sequencer
// Description : On-chip self-test sequencer for the MNIST accelerator. Walks
//               a bank of NUM_IMAGES stored images, starts the accelerator on
//               each one, waits for its done level under a timeout, compares
//               the predicted digit with the stored label and keeps pass /
//               fail / timeout statistics plus per-inference latency figures.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   run                 : one-cycle batch request (honoured in IDLE only)
//   abort               : terminate the batch from any busy state
//   label_data          : expected digit for img_idx (combinational lookup)
//   img_idx             : image / label select towards the image bank
//   acc_start           : one-cycle start pulse to the accelerator
//   acc_done, acc_digit : accelerator done level and predicted digit
//   busy                : high in every state except IDLE
//   batch_done, aborted : one-cycle completion / abort pulses
//   pass_count, fail_count, timeout_count : batch statistics
//   last_cycles, max_cycles               : latest / worst inference latency
//   first_fail_idx, first_fail_valid      : first failing image
// ============================================================================
module mnist_batch_sequencer #(
  parameter int NUM_IMAGES     = 10,
  parameter int IDX_W          = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             abort,
  input  logic [3:0]       label_data,
  output logic [IDX_W-1:0] img_idx,
  output logic             acc_start,
  input  logic             acc_done,
  input  logic [3:0]       acc_digit,
  output logic             busy,
  output logic             batch_done,
  output logic             aborted,
  output logic [IDX_W:0]   pass_count,
  output logic [IDX_W:0]   fail_count,
  output logic [IDX_W:0]   timeout_count,
  output logic [CNT_W-1:0] last_cycles,
  output logic [CNT_W-1:0] max_cycles,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_valid
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_IMAGES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_VAL      = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_NEXT   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]       state_q,      state_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic [IDX_W-1:0] img_idx_q,    img_idx_d;
  logic             match_q,      match_d;
  logic [IDX_W:0]   pass_q,       pass_d;
  logic [IDX_W:0]   fail_q,       fail_d;
  logic [IDX_W:0]   tmo_q,        tmo_d;
  logic [CNT_W-1:0] last_q,       last_d;
  logic [CNT_W-1:0] max_q,        max_d;
  logic [IDX_W-1:0] ff_idx_q,     ff_idx_d;
  logic             ff_valid_q,   ff_valid_d;
  logic             aborted_q,    aborted_d;

  // Saturating successor of the WAIT counter; doubles as the latency value
  // (counter + 1) loaded into last_cycles when done arrives.
  logic [CNT_W-1:0] wait_inc;
  assign wait_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    img_idx_d    = img_idx_q;
    match_d      = match_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    tmo_d        = tmo_q;
    last_d       = last_q;
    max_d        = max_q;
    ff_idx_d     = ff_idx_q;
    ff_valid_d   = ff_valid_q;
    aborted_d    = 1'b0;

    // Abort outranks every other action in a busy state, so statistics are
    // frozen exactly as they stood before the abort cycle.
    if ((state_q != S_IDLE) && abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run && !abort) begin
            pass_d       = '0;
            fail_d       = '0;
            tmo_d        = '0;
            last_d       = '0;
            max_d        = '0;
            ff_idx_d     = '0;
            ff_valid_d   = 1'b0;
            img_idx_d    = '0;
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            state_d      = S_START;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end

        S_START: begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end

        S_WAIT: begin
          wait_cnt_d = wait_inc;
          if (acc_done) begin
            match_d = (acc_digit == label_data);
            last_d  = wait_inc;
            if (wait_inc > max_q) begin
              max_d = wait_inc;
            end
            state_d = S_CHECK;
          end else if (wait_cnt_q == TO_LAST) begin
            // A timed-out image has no done level to drain.
            tmo_d  = tmo_q + 1'b1;
            fail_d = fail_q + 1'b1;
            last_d = TO_VAL;
            if (!ff_valid_q) begin
              ff_idx_d   = img_idx_q;
              ff_valid_d = 1'b1;
            end
            state_d = S_NEXT;
          end
        end

        S_CHECK: begin
          if (match_q) begin
            pass_d = pass_q + 1'b1;
          end else begin
            fail_d = fail_q + 1'b1;
            if (!ff_valid_q) begin
              ff_idx_d   = img_idx_q;
              ff_valid_d = 1'b1;
            end
          end
          state_d = S_DRAIN;
        end

        S_DRAIN: begin
          if (!acc_done) begin
            state_d = S_NEXT;
          end
        end

        S_NEXT: begin
          if (img_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            img_idx_d    = img_idx_q + 1'b1;
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      wait_cnt_q   <= '0;
      img_idx_q    <= '0;
      match_q      <= 1'b0;
      pass_q       <= '0;
      fail_q       <= '0;
      tmo_q        <= '0;
      last_q       <= '0;
      max_q        <= '0;
      ff_idx_q     <= '0;
      ff_valid_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      img_idx_q    <= img_idx_d;
      match_q      <= match_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      tmo_q        <= tmo_d;
      last_q       <= last_d;
      max_q        <= max_d;
      ff_idx_q     <= ff_idx_d;
      ff_valid_q   <= ff_valid_d;
      aborted_q    <= aborted_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Pulses are state decodes so an asynchronous reset clears them at once;
  // abort masks them in the very cycle it is sampled.
  assign acc_start        = (state_q == S_START) && !abort;
  assign batch_done       = (state_q == S_DONE)  && !abort;
  assign busy             = (state_q != S_IDLE);
  assign aborted          = aborted_q;
  assign img_idx          = img_idx_q;
  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign timeout_count    = tmo_q;
  assign last_cycles      = last_q;
  assign max_cycles       = max_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_valid = ff_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mnist_batch_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mnist_batch_sequencer
// Description : Scoreboard bench for mnist_batch_sequencer. Stimulus queues
//               hand-computed expected events (acc_start, batch_done,
//               aborted); a monitor pops and compares whenever the DUT emits
//               one. A small accelerator responder returns configured
//               latencies and digits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mnist_batch_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int SC = 5;
  localparam int TO = 50;
  localparam int CW = 32;

  localparam int EV_START = 0;
  localparam int EV_BATCH = 1;
  localparam int EV_ABORT = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          run   = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    label_data;
  logic [IW-1:0] img_idx;
  logic          acc_start;
  logic          acc_done  = 1'b0;
  logic [3:0]    acc_digit = 4'd0;
  logic          busy, batch_done, aborted;
  logic [IW:0]   pass_count, fail_count, timeout_count;
  logic [CW-1:0] last_cycles, max_cycles;
  logic [IW-1:0] first_fail_idx;
  logic          first_fail_valid;

  mnist_batch_sequencer #(
    .NUM_IMAGES(N), .IDX_W(IW), .SETTLE_CYCLES(SC),
    .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .abort(abort),
    .label_data(label_data), .img_idx(img_idx), .acc_start(acc_start),
    .acc_done(acc_done), .acc_digit(acc_digit), .busy(busy),
    .batch_done(batch_done), .aborted(aborted),
    .pass_count(pass_count), .fail_count(fail_count),
    .timeout_count(timeout_count), .last_cycles(last_cycles),
    .max_cycles(max_cycles), .first_fail_idx(first_fail_idx),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  // Label bank and accelerator responder configuration
  logic [3:0] label_mem [N];
  logic [3:0] dig  [N];
  int         lat  [N];   // 0 = never respond
  int         hold [N];   // cycles acc_done stays high
  assign label_data = label_mem[img_idx];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int     kind;
    int     idx;
    int     pass_c, fail_c, tmo_c;
    longint last_c, max_c;
    int     ffi, ffv;
  } exp_t;
  exp_t sb[$];

  task automatic push_start(input int idx, input longint last_c, input longint max_c);
    exp_t e;
    e = '{kind: EV_START, idx: idx, pass_c: 0, fail_c: 0, tmo_c: 0,
          last_c: last_c, max_c: max_c, ffi: 0, ffv: 0};
    sb.push_back(e);
  endtask

  task automatic push_end(input int kind, input int p, input int f, input int t,
                          input longint last_c, input longint max_c,
                          input int ffi, input int ffv);
    exp_t e;
    e = '{kind: kind, idx: 0, pass_c: p, fail_c: f, tmo_c: t,
          last_c: last_c, max_c: max_c, ffi: ffi, ffv: ffv};
    sb.push_back(e);
  endtask

  // ------------------------------------------------------------------ monitor
  exp_t m_e;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_start) begin
        chk("start_one_cycle", prev_start, 0);
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_acc_start: got 1 expected 0 (t=%0t)", $time);
        end else begin
          m_e = sb.pop_front();
          chk("event_kind_start", m_e.kind, EV_START);
          chk("start_img_idx", img_idx, m_e.idx);
          chk("start_last_cycles", last_cycles, m_e.last_c);
          chk("start_max_cycles", max_cycles, m_e.max_c);
        end
      end
      if (batch_done || aborted) begin
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_end_event: got done=%0d aborted=%0d expected none (t=%0t)",
                   batch_done, aborted, $time);
        end else begin
          m_e = sb.pop_front();
          chk("event_kind_end", batch_done ? EV_BATCH : EV_ABORT, m_e.kind);
          chk("pass_count", pass_count, m_e.pass_c);
          chk("fail_count", fail_count, m_e.fail_c);
          chk("timeout_count", timeout_count, m_e.tmo_c);
          chk("last_cycles", last_cycles, m_e.last_c);
          chk("max_cycles", max_cycles, m_e.max_c);
          chk("first_fail_idx", first_fail_idx, m_e.ffi);
          chk("first_fail_valid", first_fail_valid, m_e.ffv);
          if (aborted) chk("busy_after_abort", busy, 0);
        end
      end
    end
    prev_start = acc_start;
  end

  // ------------------------------------------------------ accelerator responder
  int m_cnt = 0, m_idx = 0, m_hold_left = 0;
  bit m_active = 1'b0;
  always @(negedge clk) begin
    if (acc_start) begin
      m_active = 1'b1;
      m_cnt    = 0;
      m_idx    = int'(img_idx);
    end else if (acc_done) begin
      m_hold_left--;
      if (m_hold_left <= 0) acc_done = 1'b0;
    end else if (m_active) begin
      m_cnt++;
      if (lat[m_idx] != 0 && m_cnt == lat[m_idx]) begin
        acc_done    = 1'b1;
        acc_digit   = dig[m_idx];
        m_hold_left = hold[m_idx];
        m_active    = 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- helpers
  task automatic cfg(input int l0, input int l1, input int l2, input int l3,
                     input logic [3:0] d0, input logic [3:0] d1,
                     input logic [3:0] d2, input logic [3:0] d3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
    for (int i = 0; i < N; i++) hold[i] = 1;
  endtask

  task automatic run_batch(input bit check_lat);
    int n;
    @(negedge clk); run = 1'b1;
    n = 0;
    do begin
      @(negedge clk); run = 1'b0; n++;
    end while (!acc_start && n < 200);
    if (check_lat) chk("run_to_acc_start", n, SC + 1);
  endtask

  task automatic wait_next_start();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!acc_start && n < 200);
    chk("next_start_seen", (n < 200), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    chk("idle_reached", (n < 5000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_img_idx"}, img_idx, 0);
    chk({tag, "_acc_start"}, acc_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_batch_done"}, batch_done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_pass"}, pass_count, 0);
    chk({tag, "_fail"}, fail_count, 0);
    chk({tag, "_timeout"}, timeout_count, 0);
    chk({tag, "_last"}, last_cycles, 0);
    chk({tag, "_max"}, max_cycles, 0);
    chk({tag, "_ffi"}, first_fail_idx, 0);
    chk({tag, "_ffv"}, first_fail_valid, 0);
  endtask

  task automatic push_normal();
    push_start(0, 0, 0); push_start(1, 10, 10);
    push_start(2, 10, 10); push_start(3, 10, 10);
    push_end(EV_BATCH, 4, 0, 0, 10, 10, 0, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    label_mem[0] = 4'd3; label_mem[1] = 4'd7;
    label_mem[2] = 4'd1; label_mem[3] = 4'd9;
    cfg(10, 10, 10, 10, 4'd3, 4'd7, 4'd1, 4'd9);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal batch: all correct, latency 10, run-to-start latency measured
    push_normal();
    run_batch(1'b1);
    wait_idle();

    // Mispredictions on images 1 and 3
    cfg(10, 10, 10, 10, 4'd3, 4'd6, 4'd1, 4'd8);
    push_start(0, 0, 0); push_start(1, 10, 10);
    push_start(2, 10, 10); push_start(3, 10, 10);
    push_end(EV_BATCH, 2, 2, 0, 10, 10, 1, 1);
    run_batch(1'b0);
    wait_idle();

    // Timeout on image 2; last_cycles shows 50 when image 3 starts
    cfg(10, 10, 0, 10, 4'd3, 4'd7, 4'd1, 4'd9);
    push_start(0, 0, 0); push_start(1, 10, 10);
    push_start(2, 10, 10); push_start(3, 50, 10);
    push_end(EV_BATCH, 3, 1, 1, 10, 10, 2, 1);
    run_batch(1'b0);
    wait_idle();

    // Variable latency 7, 30, 12, 5; image 1 holds done for 3 cycles
    cfg(7, 30, 12, 5, 4'd3, 4'd7, 4'd1, 4'd9);
    hold[1] = 3;
    push_start(0, 0, 0); push_start(1, 7, 7);
    push_start(2, 30, 30); push_start(3, 12, 30);
    push_end(EV_BATCH, 4, 0, 0, 5, 30, 0, 0);
    run_batch(1'b0);
    wait_idle();

    // Abort during WAIT of image 1
    cfg(10, 10, 10, 10, 4'd3, 4'd7, 4'd1, 4'd9);
    push_start(0, 0, 0); push_start(1, 10, 10);
    push_end(EV_ABORT, 1, 0, 0, 10, 10, 0, 0);
    run_batch(1'b0);
    wait_next_start();
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_after_abort", busy, 0);
    chk("sb_drained_after_abort", sb.size(), 0);

    // Following run starts from cleared statistics
    push_normal();
    run_batch(1'b0);
    wait_idle();

    // Reset mid-WAIT: outputs drop at once, next run restarts at image 0
    push_start(0, 0, 0);
    run_batch(1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push_normal();
    run_batch(1'b1);
    wait_idle();

    // run and abort together in IDLE: stays idle, no aborted pulse
    @(negedge clk); run = 1'b1; abort = 1'b1;
    @(negedge clk); run = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("run_abort_idle_busy", busy, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
